// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle, shift-add multiply, restoring divide.
// Define MDU_FAST_SPECIAL_EN to send divide-by-zero and signed overflow straight from IDLE to DONE.
module mul_div_unit #(
    parameter int Reg_size = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [2:0]                 funct3,
    input  logic signed [Reg_size-1:0] rs1_data,
    input  logic signed [Reg_size-1:0] rs2_data,
    output logic                       busy,
    output logic                       done,
    output logic signed [Reg_size-1:0] result
);

    localparam int W  = Reg_size;
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LastCount = CW'(W - 1);
    localparam logic [W-1:0]  MinNeg    = {1'b1, {(W-1){1'b0}}};

`ifdef MDU_FAST_SPECIAL_EN
    localparam bit FastSpecial = 1'b1;
`else
    localparam bit FastSpecial = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t state_reg, state_next;

    logic [CW-1:0] count_reg;
    logic [2:0]    op_reg;
    logic [W-1:0]  rs1_reg;
    logic [W-1:0]  mcand_reg;
    logic [W-1:0]  hi_reg;
    logic [W-1:0]  lo_reg;
    logic          q_neg_reg;
    logic          r_neg_reg;
    logic          dz_reg;
    logic          ovf_reg;
    logic [W-1:0]  result_reg;

    // Forced results for divide by zero (div_zero=1) or signed overflow (div_zero=0).
    function automatic logic [W-1:0] special_value(input logic [2:0] op,
                                                   input logic [W-1:0] dividend,
                                                   input logic div_zero);
        if (div_zero)
            return op[1] ? dividend : {W{1'b1}};
        return op[1] ? {W{1'b0}} : dividend;
    endfunction

    // Operand decode at issue time: signedness, magnitudes and special cases.
    logic [W-1:0] a_raw, b_raw, a_mag_in, b_mag_in;
    logic         a_signed_in, b_signed_in, a_neg_in, b_neg_in;
    logic         dz_in, ovf_in, special_in, fast_take;

    always_comb begin
        a_raw       = rs1_data;
        b_raw       = rs2_data;
        a_signed_in = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
        b_signed_in = funct3[2] ? ~funct3[0] : ~funct3[1];
        a_neg_in    = a_signed_in & a_raw[W-1];
        b_neg_in    = b_signed_in & b_raw[W-1];
        a_mag_in    = a_neg_in ? (~a_raw + 1'b1) : a_raw;
        b_mag_in    = b_neg_in ? (~b_raw + 1'b1) : b_raw;
        dz_in       = funct3[2] && (b_raw == '0);
        ovf_in      = funct3[2] && !funct3[0] && (a_raw == MinNeg) && (b_raw == {W{1'b1}});
        special_in  = dz_in | ovf_in;
        fast_take   = special_in & FastSpecial;
    end

    // One iteration step; hi/lo hold the running product or remainder/quotient.
    logic [W:0]   add_sum;
    logic [W:0]   shifted;
    logic [W+1:0] diff;
    logic [W-1:0] hi_next, lo_next;

    always_comb begin
        add_sum = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, mcand_reg} : {(W+1){1'b0}});
        shifted = {hi_reg, lo_reg[W-1]};
        diff    = {1'b0, shifted} - {2'b00, mcand_reg};
        if (op_reg[2]) begin
            if (!diff[W+1]) begin
                hi_next = diff[W-1:0];
                lo_next = {lo_reg[W-2:0], 1'b1};
            end else begin
                hi_next = shifted[W-1:0];
                lo_next = {lo_reg[W-2:0], 1'b0};
            end
        end else begin
            hi_next = add_sum[W:1];
            lo_next = {add_sum[0], lo_reg[W-1:1]};
        end
    end

    // Sign fix-up of the final step's values, then result selection.
    logic [2*W-1:0] prod, prod_fix;
    logic [W-1:0]   quot_fix, rem_fix, calc_result;

    always_comb begin
        prod     = {hi_next, lo_next};
        prod_fix = q_neg_reg ? (~prod + 1'b1) : prod;
        quot_fix = q_neg_reg ? (~lo_next + 1'b1) : lo_next;
        rem_fix  = r_neg_reg ? (~hi_next + 1'b1) : hi_next;
        if (op_reg[2])
            calc_result = op_reg[1] ? rem_fix : quot_fix;
        else
            calc_result = (op_reg[1:0] == 2'b00) ? prod_fix[W-1:0] : prod_fix[2*W-1:W];
        if (dz_reg | ovf_reg)
            calc_result = special_value(op_reg, rs1_reg, dz_reg);
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = fast_take ? DONE : CALC;
            CALC:    if (count_reg == LastCount) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg  <= '0;
            op_reg     <= '0;
            rs1_reg    <= '0;
            mcand_reg  <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            q_neg_reg  <= 1'b0;
            r_neg_reg  <= 1'b0;
            dz_reg     <= 1'b0;
            ovf_reg    <= 1'b0;
            result_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        count_reg <= '0;
                        op_reg    <= funct3;
                        rs1_reg   <= a_raw;
                        mcand_reg <= b_mag_in;
                        hi_reg    <= '0;
                        lo_reg    <= a_mag_in;
                        q_neg_reg <= a_neg_in ^ b_neg_in;
                        r_neg_reg <= a_neg_in;
                        dz_reg    <= dz_in;
                        ovf_reg   <= ovf_in;
                        if (fast_take)
                            result_reg <= special_value(funct3, a_raw, dz_in);
                    end
                end
                CALC: begin
                    hi_reg    <= hi_next;
                    lo_reg    <= lo_next;
                    count_reg <= count_reg + 1'b1;
                    if (count_reg == LastCount)
                        result_reg <= calc_result;
                end
                default: ;
            endcase
        end
    end

    assign busy   = (state_reg != IDLE);
    assign done   = (state_reg == DONE);
    assign result = result_reg;

endmodule
